// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads > buffered host writes > host reads.
// Optional macro VRAM_ARB_BLANK_ONLY_EN limits host writes/reads to vertical blanking.
module vram_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vert_blanking,
   input  logic                  disp_req,
   input  logic [ADDR_WIDTH-1:0] disp_addr,
   output logic [DATA_WIDTH-1:0] disp_data,
   output logic                  disp_valid,
   input  logic                  host_wr_valid,
   input  logic [ADDR_WIDTH-1:0] host_wr_addr,
   input  logic [DATA_WIDTH-1:0] host_wr_data,
   output logic                  host_wr_ready,
   input  logic                  host_rd_valid,
   input  logic [ADDR_WIDTH-1:0] host_rd_addr,
   output logic                  host_rd_ready,
   output logic [DATA_WIDTH-1:0] host_rd_data,
   output logic                  host_rd_data_valid,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);
   localparam int IW = $clog2(FIFO_DEPTH);
   localparam int PW = IW + 1;

   logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  active_q;
   logic                  disp_vld_q, disp_vld_d;
   logic                  rd_vld_q, rd_vld_d;
   logic [DATA_WIDTH-1:0] rd_hold_q, rd_hold_d;
   logic [ADDR_WIDTH-1:0] last_addr_q;
   logic [DATA_WIDTH-1:0] last_wdata_q;
   logic                  fifo_empty, fifo_full, blank_ok, push;
   logic                  grant_disp, grant_drain, grant_rd;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_data;

`ifdef VRAM_ARB_BLANK_ONLY_EN
   assign blank_ok = vert_blanking;
`else
   logic unused_vert_blanking;
   assign unused_vert_blanking = vert_blanking;
   assign blank_ok = 1'b1;
`endif

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                       (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
   assign head_addr  = fifo_addr_q[rd_ptr_q[IW-1:0]];
   assign head_data  = fifo_data_q[rd_ptr_q[IW-1:0]];

   assign host_wr_ready = active_q & ~fifo_full;
   assign push          = host_wr_valid & host_wr_ready;

   // Reads wait for an empty FIFO so they can never overtake a buffered write.
   assign grant_disp    = rst_n & disp_req;
   assign grant_drain   = ~disp_req & ~fifo_empty & blank_ok;
   assign grant_rd      = active_q & host_rd_valid & ~disp_req & fifo_empty & blank_ok;
   assign host_rd_ready = grant_rd;

   always_comb begin
      ram_addr  = last_addr_q;
      ram_wdata = last_wdata_q;
      ram_we    = 1'b0;
      if (grant_disp) begin
         ram_addr = disp_addr;
      end else if (grant_drain) begin
         ram_addr  = head_addr;
         ram_wdata = head_data;
         ram_we    = 1'b1;
      end else if (grant_rd) begin
         ram_addr = host_rd_addr;
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q + {{IW{1'b0}}, push};
      rd_ptr_d   = rd_ptr_q + {{IW{1'b0}}, grant_drain};
      disp_vld_d = grant_disp;
      rd_vld_d   = grant_rd;
      rd_hold_d  = rd_vld_q ? ram_rdata : rd_hold_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         active_q     <= 1'b0;
         disp_vld_q   <= 1'b0;
         rd_vld_q     <= 1'b0;
         rd_hold_q    <= '0;
         last_addr_q  <= '0;
         last_wdata_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         active_q     <= 1'b1;
         disp_vld_q   <= disp_vld_d;
         rd_vld_q     <= rd_vld_d;
         rd_hold_q    <= rd_hold_d;
         last_addr_q  <= ram_addr;
         last_wdata_q <= ram_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q[IW-1:0]] <= host_wr_addr;
         fifo_data_q[wr_ptr_q[IW-1:0]] <= host_wr_data;
      end
   end

   // RAM data appears live in the response cycle; host data is then held.
   assign disp_valid         = disp_vld_q;
   assign disp_data          = disp_vld_q ? ram_rdata : '0;
   assign host_rd_data_valid = rd_vld_q;
   assign host_rd_data       = rd_vld_q ? ram_rdata : rd_hold_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, per-cycle scoreboard monitor and scenario tasks.
module tb_vram_arbiter;
   localparam int AW    = 12;
   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n, vert_blanking, disp_req;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_data;
   logic          disp_valid;
   logic          host_wr_valid;
   logic [AW-1:0] host_wr_addr;
   logic [DW-1:0] host_wr_data;
   logic          host_wr_ready;
   logic          host_rd_valid;
   logic [AW-1:0] host_rd_addr;
   logic          host_rd_ready;
   logic [DW-1:0] host_rd_data;
   logic          host_rd_data_valid;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [AW+DW-1:0] exp_wr_q[$];
   logic [DW-1:0]    exp_disp_q[$];
   logic [DW-1:0]    exp_rd_q[$];

   vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .vert_blanking(vert_blanking),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
      .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
      .host_wr_ready(host_wr_ready), .host_rd_valid(host_rd_valid), .host_rd_addr(host_rd_addr),
      .host_rd_ready(host_rd_ready), .host_rd_data(host_rd_data),
      .host_rd_data_valid(host_rd_data_valid), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [DW-1:0] pat(input int a);
      logic [DW-1:0] r;
      r = DW'(a);
      return r ^ 8'h3C;
   endfunction

   // Synchronous single-port RAM, read-first, 1-cycle latency.
   initial begin : ram_model
      logic [DW-1:0] ram [1<<AW];
      logic [DW-1:0] rd;
      for (int i = 0; i < (1<<AW); i++) ram[i] = pat(i);
      forever begin
         @(posedge clk);
         rd = ram[ram_addr];
         if (ram_we === 1'b1) ram[ram_addr] = ram_wdata;
         ram_rdata <= rd;
      end
   end

   // Reference behaviour checked every cycle on the falling edge.
   initial begin : monitor
      logic [DW-1:0]    ref_mem [1<<AW];
      logic [AW+DW-1:0] head;
      logic [DW-1:0]    e;
      logic             blank_ok, exp_we, exp_rrdy, exp_wrdy;
      logic             prev_disp, prev_rd, active_m;
      int               count_m;
      prev_disp = 0; prev_rd = 0; active_m = 0; count_m = 0;
      for (int i = 0; i < (1<<AW); i++) ref_mem[i] = pat(i);
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            count_m = 0; active_m = 0; prev_disp = 0; prev_rd = 0;
            exp_wr_q.delete(); exp_disp_q.delete(); exp_rd_q.delete();
            n_cmp++;
            if ({host_wr_ready, host_rd_ready, disp_valid, host_rd_data_valid, ram_we} !== 5'b0 ||
                ram_addr !== '0 || ram_wdata !== '0 || disp_data !== '0 || host_rd_data !== '0) begin
               n_fail++;
               $display("FAIL reset_outputs: got wr_rdy=%b rd_rdy=%b dv=%b rdv=%b we=%b addr=%h wd=%h dd=%h rd=%h, required all 0",
                        host_wr_ready, host_rd_ready, disp_valid, host_rd_data_valid, ram_we,
                        ram_addr, ram_wdata, disp_data, host_rd_data);
            end
         end else begin
`ifdef VRAM_ARB_BLANK_ONLY_EN
            blank_ok = vert_blanking;
`else
            blank_ok = 1'b1;
`endif
            exp_we   = !disp_req && count_m != 0 && blank_ok;
            exp_rrdy = active_m && host_rd_valid && !disp_req && count_m == 0 && blank_ok;
            exp_wrdy = active_m && count_m < DEPTH;

            n_cmp++;
            if (disp_valid !== prev_disp) begin
               n_fail++;
               $display("FAIL disp_valid: got %b required %b", disp_valid, prev_disp);
            end
            if (prev_disp && exp_disp_q.size() > 0) begin
               e = exp_disp_q.pop_front();
               n_cmp++;
               if (disp_data !== e) begin
                  n_fail++;
                  $display("FAIL disp_data: got %h required %h", disp_data, e);
               end
            end

            n_cmp++;
            if (host_rd_data_valid !== prev_rd) begin
               n_fail++;
               $display("FAIL rd_data_valid: got %b required %b", host_rd_data_valid, prev_rd);
            end
            if (prev_rd && exp_rd_q.size() > 0) begin
               e = exp_rd_q.pop_front();
               n_cmp++;
               if (host_rd_data !== e) begin
                  n_fail++;
                  $display("FAIL rd_data: got %h required %h", host_rd_data, e);
               end
            end

            n_cmp++;
            if (ram_we !== exp_we) begin
               n_fail++;
               $display("FAIL ram_we: got %b required %b", ram_we, exp_we);
            end
            if (exp_we && exp_wr_q.size() > 0) begin
               head = exp_wr_q.pop_front();
               n_cmp++;
               if ({ram_addr, ram_wdata} !== head) begin
                  n_fail++;
                  $display("FAIL drain_entry: got addr=%h data=%h required addr=%h data=%h",
                           ram_addr, ram_wdata, head[AW+DW-1:DW], head[DW-1:0]);
               end
               ref_mem[head[AW+DW-1:DW]] = head[DW-1:0];
            end

            if (disp_req) begin
               n_cmp++;
               if (ram_addr !== disp_addr) begin
                  n_fail++;
                  $display("FAIL disp_ram_addr: got %h required %h", ram_addr, disp_addr);
               end
            end

            n_cmp++;
            if (host_rd_ready !== exp_rrdy) begin
               n_fail++;
               $display("FAIL host_rd_ready: got %b required %b", host_rd_ready, exp_rrdy);
            end
            n_cmp++;
            if (host_wr_ready !== exp_wrdy) begin
               n_fail++;
               $display("FAIL host_wr_ready: got %b required %b", host_wr_ready, exp_wrdy);
            end

            if (disp_req) exp_disp_q.push_back(ref_mem[disp_addr]);
            if (exp_rrdy) exp_rd_q.push_back(ref_mem[host_rd_addr]);
            if (host_wr_valid && exp_wrdy) exp_wr_q.push_back({host_wr_addr, host_wr_data});
            count_m = count_m + ((host_wr_valid && exp_wrdy) ? 1 : 0) - (exp_we ? 1 : 0);
            prev_disp = disp_req;
            prev_rd   = exp_rrdy;
            active_m  = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (host_wr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wr_ready: got %b required 0", host_wr_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (host_wr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_ready_before_edge: got %b required 0", host_wr_ready);
      end
      tick();
      n_cmp++;
      if (host_wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_ready_first_edge: got %b required 1", host_wr_ready);
      end
   endtask

   task automatic test_disp_stream();
      disp_req = 1'b1; disp_addr = 12'h010;
      host_rd_valid = 1'b1; host_rd_addr = 12'h200;
      @(negedge clk);
      n_cmp++;
      if (ram_addr !== 12'h010 || ram_we !== 1'b0 || host_rd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL disp_grant: got addr=%h we=%b rd_rdy=%b required 010/0/0", ram_addr, ram_we, host_rd_ready);
      end
      tick();
      disp_addr = 12'h011;
      @(negedge clk);
      n_cmp++;
      if (disp_valid !== 1'b1 || disp_data !== pat(12'h010) || host_rd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL disp_first: got dv=%b data=%h rd_rdy=%b required 1/%h/0", disp_valid, disp_data, host_rd_ready, pat(12'h010));
      end
      tick();
      disp_req = 1'b0; host_rd_valid = 1'b0; disp_addr = '0;
      @(negedge clk);
      n_cmp++;
      if (disp_valid !== 1'b1 || disp_data !== pat(12'h011)) begin
         n_fail++;
         $display("FAIL disp_second: got dv=%b data=%h required 1/%h", disp_valid, disp_data, pat(12'h011));
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (disp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL disp_idle: got %b required 0", disp_valid);
      end
   endtask

   task automatic test_fifo_full_drain();
      int first, last, nwr;
      bit accepted;
      tick();
      disp_req = 1'b1; disp_addr = 12'h020;
      for (int i = 0; i < 5; i++) begin
         host_wr_valid = 1'b1;
         host_wr_addr  = 12'(12'h300 + i);
         host_wr_data  = 8'(8'h80 + i);
         @(negedge clk);
         n_cmp++;
         if (host_wr_ready !== (i < 4)) begin
            n_fail++;
            $display("FAIL fill_ready_%0d: got %b required %b", i, host_wr_ready, (i < 4));
         end
         if (i < 4) tick();
      end
      repeat (2) begin
         tick();
         @(negedge clk);
         n_cmp++;
         if (host_wr_ready !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL full_hold: got ready=%b we=%b required 0/0", host_wr_ready, ram_we);
         end
      end
      tick();
      disp_req = 1'b0;
      first = -1; last = -1; nwr = 0; accepted = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (ram_we === 1'b1) begin
            n_cmp++;
            if (ram_addr !== 12'(12'h300 + nwr)) begin
               n_fail++;
               $display("FAIL drain_addr_%0d: got %h required %h", nwr, ram_addr, 12'(12'h300 + nwr));
            end
            if (first < 0) first = c;
            last = c;
            nwr++;
         end
         if (host_wr_valid && host_wr_ready) accepted = 1;
         tick();
         if (accepted) host_wr_valid = 1'b0;
      end
      n_cmp++;
      if (nwr != 5 || last - first != 4) begin
         n_fail++;
         $display("FAIL drain_run: got %0d writes over %0d cycles required 5 over 5", nwr, last - first + 1);
      end
   endtask

   task automatic test_raw();
      bit got;
      tick();
      host_wr_valid = 1'b1; host_wr_addr = 12'h123; host_wr_data = 8'hA5;
      @(negedge clk);
      n_cmp++;
      if (host_wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL raw_wr_ready: got %b required 1", host_wr_ready);
      end
      tick();
      host_wr_valid = 1'b0; host_rd_valid = 1'b1; host_rd_addr = 12'h123;
      @(negedge clk);
      n_cmp++;
      if (host_rd_ready !== 1'b0 || ram_we !== 1'b1) begin
         n_fail++;
         $display("FAIL raw_rd_wait: got rd_rdy=%b we=%b required 0/1", host_rd_ready, ram_we);
      end
      got = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         @(negedge clk);
         if (host_rd_ready === 1'b1) begin
            got = 1;
            break;
         end
      end
      n_cmp++;
      if (!got) begin
         n_fail++;
         $display("FAIL raw_rd_timeout: got no host_rd_ready required one within 8 cycles");
      end
      tick();
      host_rd_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (host_rd_data_valid !== 1'b1 || host_rd_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL raw_rd_data: got v=%b data=%h required 1/a5", host_rd_data_valid, host_rd_data);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (host_rd_data_valid !== 1'b0 || host_rd_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL raw_rd_hold: got v=%b data=%h required 0/a5", host_rd_data_valid, host_rd_data);
      end
      tick();
      host_rd_valid = 1'b1; host_rd_addr = 12'h055;
      @(negedge clk);
      n_cmp++;
      if (host_rd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL plain_rd_ready: got %b required 1", host_rd_ready);
      end
      tick();
      host_rd_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (host_rd_data_valid !== 1'b1 || host_rd_data !== 8'h69) begin
         n_fail++;
         $display("FAIL plain_rd_data: got v=%b data=%h required 1/69", host_rd_data_valid, host_rd_data);
      end
   endtask

   task automatic test_reset_midop();
      tick();
      disp_req = 1'b1; disp_addr = 12'h030;
      host_wr_valid = 1'b1; host_wr_addr = 12'h500; host_wr_data = 8'h11;
      tick();
      host_wr_addr = 12'h501; host_wr_data = 8'h22;
      tick();
      host_wr_valid = 1'b0; disp_req = 1'b0; rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (host_wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_wr_ready: got %b required 1", host_wr_ready);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_cmp++;
         if (ram_we !== 1'b0 || disp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet_%0d: got we=%b dv=%b required 0/0", c, ram_we, disp_valid);
         end
         tick();
      end
      host_rd_valid = 1'b1; host_rd_addr = 12'h066;
      @(negedge clk);
      n_cmp++;
      if (host_rd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_rd_ready: got %b required 1", host_rd_ready);
      end
      tick();
      rst_n = 1'b0; host_rd_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++;
         if (host_rd_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_rd_drop_%0d: got %b required 0", c, host_rd_data_valid);
         end
         tick();
      end
   endtask

   task automatic test_blank_gate();
      vert_blanking = 1'b0;
      tick();
      host_wr_valid = 1'b1; host_wr_addr = 12'h456; host_wr_data = 8'h3E;
      tick();
      host_wr_valid = 1'b0;
`ifdef VRAM_ARB_BLANK_ONLY_EN
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if (ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_hold_%0d: got we=%b required 0", c, ram_we);
         end
         tick();
      end
      vert_blanking = 1'b1;
`endif
      @(negedge clk);
      n_cmp++;
      if (ram_we !== 1'b1 || ram_addr !== 12'h456 || ram_wdata !== 8'h3E) begin
         n_fail++;
         $display("FAIL blank_write: got we=%b addr=%h data=%h required 1/456/3e", ram_we, ram_addr, ram_wdata);
      end
      tick();
      vert_blanking = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; vert_blanking = 1'b1; disp_req = 1'b0; disp_addr = '0;
      host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
      host_rd_valid = 1'b0; host_rd_addr = '0;
      test_reset();
      test_disp_stream();
      test_fifo_full_drain();
      test_raw();
      test_reset_midop();
      test_blank_gate();
      repeat (4) tick();
      n_cmp++;
      if (exp_wr_q.size() != 0 || exp_disp_q.size() != 0 || exp_rd_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_expect: got wr=%0d disp=%0d rd=%0d pending required 0",
                  exp_wr_q.size(), exp_disp_q.size(), exp_rd_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
